// File: rtl/lcd_bus_writer_pkg.sv
// Shared state encoding and ILI9341 command opcodes for the LCD write path.
// The upstream vma412 sequencer uses the command constants to build its init and pixel streams.
package lcd_pkg;

  typedef enum logic [2:0] {
    RST_LOW  = 3'd0,
    RST_WAIT = 3'd1,
    IDLE     = 3'd2,
    SETUP    = 3'd3,
    WR_LOW   = 3'd4,
    WR_HIGH  = 3'd5
  } lcd_state_t;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_writer_if.sv
// Byte handshake between the command/pixel sequencer (master) and the bus write engine (slave).
// in_dc selects command (0) or parameter/pixel data (1).
interface lcd_bus_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       in_dc;

  modport master (output in_valid, output in_byte, output in_dc, input in_ready);
  modport slave  (input in_valid, input in_byte, input in_dc, output in_ready);
endinterface

// File: rtl/lcd_bus_writer_cycle_timer.sv
// Loadable down-counter shared by the reset, strobe and chip-select idle phases.
// Latency: done is high while the count is zero; a load takes effect on the next edge.
// Backpressure: none, the owning FSM decides when to load.
module lcd_cycle_timer #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   INIT = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= INIT;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// 8080-style 8-bit write engine for the ILI9341 panel; LCD_HWRESET_EN adds the resx power-up sequence.
// Latency: wrx falls 1 clock after accept and rises WR_LOW_CYCLES later; one byte per 1+WR_LOW+WR_HIGH clocks.
// Backpressure: in_ready depends only on state/timer, high in IDLE and on the last WR_HIGH clock.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int WR_LOW_CYCLES    = 2,
  parameter int WR_HIGH_CYCLES   = 2,
  parameter int RESX_LOW_CYCLES  = 500,
  parameter int RESX_WAIT_CYCLES = 6000000,
  parameter int CS_IDLE_CYCLES   = 4
) (
  input  logic             clock,
  input  logic             reset,
  lcd_bus_writer_if.slave  up,
  output logic             busy,
  output logic [7:0]       data,
  output logic             csx,
  output logic             resx,
  output logic             dcx,
  output logic             wrx,
  output logic             rdx
);

  localparam int MAXV = max_of(max_of(max_of(WR_LOW_CYCLES, WR_HIGH_CYCLES),
                                      max_of(RESX_LOW_CYCLES, RESX_WAIT_CYCLES)),
                               CS_IDLE_CYCLES);
  localparam int W = $clog2(MAXV + 1);

  localparam logic [W-1:0] WRL_LD = W'(WR_LOW_CYCLES - 1);
  localparam logic [W-1:0] WRH_LD = W'(WR_HIGH_CYCLES - 1);
  localparam logic [W-1:0] RSL_LD = W'(RESX_LOW_CYCLES - 1);
  localparam logic [W-1:0] RSW_LD = W'(RESX_WAIT_CYCLES - 1);
  localparam logic [W-1:0] CSI_LD = (CS_IDLE_CYCLES > 0) ? W'(CS_IDLE_CYCLES - 1) : '0;

`ifdef LCD_HWRESET_EN
  localparam lcd_state_t   INIT_STATE = RST_LOW;
  localparam logic [W-1:0] TMR_INIT   = RSL_LD;
`else
  localparam lcd_state_t   INIT_STATE = IDLE;
  localparam logic [W-1:0] TMR_INIT   = '0;
`endif

  lcd_state_t   state;
  logic         tmr_load;
  logic [W-1:0] tmr_val;
  logic         tmr_done;
  logic         xfer;

  lcd_cycle_timer #(.W(W), .INIT(TMR_INIT)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign up.in_ready = (state == IDLE) || ((state == WR_HIGH) && tmr_done);
  assign xfer        = up.in_valid && up.in_ready;
  assign busy        = (state != IDLE);
  assign rdx         = 1'b1;

  // The timer also measures the post-write idle gap that releases csx.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      RST_LOW:  if (tmr_done) begin tmr_load = 1'b1; tmr_val = RSW_LD; end
      SETUP:    begin tmr_load = 1'b1; tmr_val = WRL_LD; end
      WR_LOW:   if (tmr_done) begin tmr_load = 1'b1; tmr_val = WRH_LD; end
      WR_HIGH:  if (tmr_done && !up.in_valid) begin tmr_load = 1'b1; tmr_val = CSI_LD; end
      default:  ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= INIT_STATE;
      data  <= 8'h00;
      csx   <= 1'b1;
      dcx   <= 1'b1;
      wrx   <= 1'b1;
`ifdef LCD_HWRESET_EN
      resx  <= 1'b0;
`endif
    end else begin
      case (state)
`ifdef LCD_HWRESET_EN
        RST_LOW: if (tmr_done) begin
          state <= RST_WAIT;
          resx  <= 1'b1;
        end
        RST_WAIT: if (tmr_done) state <= IDLE;
`endif
        IDLE: begin
          if (xfer) begin
            state <= SETUP;
            data  <= up.in_byte;
            dcx   <= up.in_dc;
            csx   <= 1'b0;
          end else if (!csx && tmr_done && (CS_IDLE_CYCLES != 0)) begin
            csx <= 1'b1;
          end
        end
        SETUP: begin
          state <= WR_LOW;
          wrx   <= 1'b0;
        end
        WR_LOW: if (tmr_done) begin
          state <= WR_HIGH;
          wrx   <= 1'b1;
        end
        WR_HIGH: if (tmr_done) begin
          if (xfer) begin
            state <= SETUP;
            data  <= up.in_byte;
            dcx   <= up.in_dc;
            csx   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef LCD_HWRESET_EN
  assign resx = 1'b1;
`endif

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Scoreboard bench for lcd_bus_writer: accepted bytes are queued with their expected latch cycle,
// and a negedge monitor checks every wrx rising edge against the queue head.
module tb_lcd_bus_writer;
  import lcd_pkg::*;

  localparam int L   = 2;
  localparam int H   = 2;
  localparam int RL  = 4;
  localparam int RW  = 8;
  localparam int CSI = 4;
  localparam int PER = 1 + L + H;
`ifdef LCD_HWRESET_EN
  localparam bit HW = 1'b1;
`else
  localparam bit HW = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       busy, csx, resx, dcx, wrx, rdx;
  logic [7:0] data;

  lcd_bus_writer_if bus();

  lcd_bus_writer #(
    .WR_LOW_CYCLES    (L),
    .WR_HIGH_CYCLES   (H),
    .RESX_LOW_CYCLES  (RL),
    .RESX_WAIT_CYCLES (RW),
    .CS_IDLE_CYCLES   (CSI)
  ) dut (
    .clock (clock),
    .reset (reset),
    .up    (bus),
    .busy  (busy),
    .data  (data),
    .csx   (csx),
    .resx  (resx),
    .dcx   (dcx),
    .wrx   (wrx),
    .rdx   (rdx)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    logic       dc;
    int         t;
  } exp_t;

  exp_t       expq[$];
  exp_t       e_mon;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         rises = 0;
  int         accepted = 0;
  int         last_rise = -100;
  int         low_cnt = 0;
  int         stream_prev = -1;
  bit         stream_on = 1'b0;
  logic       prev_wrx = 1'b1;
  logic       prev_dcx = 1'b1;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Latch monitor: the panel captures data/dcx on each wrx rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      prev_wrx = 1'b1;
      low_cnt  = 0;
    end else begin
      if (!wrx && !prev_wrx) begin
        chk("data_hold", data, prev_data);
        chk("dcx_hold", dcx, prev_dcx);
      end
      if (!wrx) low_cnt++;
      if (wrx && !prev_wrx) begin
        rises++;
        chk("wrx_low_width", low_cnt, L);
        chk("csx_at_latch", csx, 0);
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_wrx_rise: data %0h latched with no byte pending (cycle %0d)", prev_data, cyc);
        end else begin
          e_mon = expq.pop_front();
          chk("latch_data", prev_data, e_mon.b);
          chk("latch_dcx", prev_dcx, e_mon.dc);
          chk("latch_cycle", cyc, e_mon.t);
        end
        if (stream_on) begin
          if (stream_prev >= 0) chk("stream_period", cyc - stream_prev, PER);
          stream_prev = cyc;
        end
        last_rise = cyc;
        low_cnt   = 0;
      end
      prev_wrx  = wrx;
      prev_data = data;
      prev_dcx  = dcx;
    end
  end

  // Presents a byte and holds it until accepted; expected latch is 2+L edges after the sampling negedge.
  task automatic send(input logic [7:0] b, input logic dc, input bit skip_wait);
    int   n;
    bit   done;
    exp_t e;
    n    = 0;
    done = 1'b0;
    if (!skip_wait) @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_dc    = dc;
    while (!done) begin
      #1;
      if (bus.in_ready) begin
        e.b  = b;
        e.dc = dc;
        e.t  = cyc + 2 + L;
        expq.push_back(e);
        accepted++;
        done = 1'b1;
      end
      @(posedge clock);
      if (!done) begin
        n++;
        if (n > 200) begin
          tests++;
          fails++;
          $display("FAIL send_timeout: in_ready %0d after %0d cycles", bus.in_ready, n);
          bus.in_valid = 1'b0;
          done = 1'b1;
        end else begin
          @(negedge clock);
        end
      end
    end
  endtask

  task automatic drop_valid();
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("drain_queue_empty", expq.size(), 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_data", data, 8'h00);
    chk("rst_csx", csx, 1);
    chk("rst_dcx", dcx, 1);
    chk("rst_wrx", wrx, 1);
    chk("rst_rdx", rdx, 1);
    chk("rst_busy", busy, HW ? 1 : 0);
    chk("rst_resx", resx, HW ? 0 : 1);
    chk("rst_in_ready", bus.in_ready, HW ? 0 : 1);
  endtask

  // Releases reset on a negedge and follows the resx sequence; returns at the negedge where in_ready is due.
  task automatic release_check();
    int last;
    last = HW ? (RL + RW) : 0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k <= last; k++) begin
      if (k != 0) @(negedge clock);
      #1;
      chk("seq_resx", resx, HW ? (k >= RL) : 1);
      chk("seq_in_ready", bus.in_ready, HW ? (k >= RL + RW) : 1);
      chk("seq_csx", csx, 1);
      chk("seq_wrx", wrx, 1);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r0;
    int n;
    int rises_before;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_dc    = 1'b0;

    repeat (3) @(negedge clock);
    #1;
    check_reset_vals();

    // Single command, accepted on the first available cycle after reset.
    release_check();
    send(CMD_RAMWR, 1'b0, 1'b1);
    drop_valid();
    r0 = rises;
    n  = 0;
    while (rises == r0 && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("single_latched", rises, r0 + 1);
    chk("single_data_on_bus", data, CMD_RAMWR);
    chk("single_dcx_on_bus", dcx, 0);
    repeat (H + CSI - 1) @(negedge clock);
    #1;
    chk("csx_before_idle_timeout", csx, 0);
    chk("cyc_align_idle", cyc - last_rise, H + CSI - 1);
    @(negedge clock);
    #1;
    chk("csx_after_idle_timeout", csx, 1);
    chk("idle_busy", busy, 0);

    // Back-to-back stream with in_valid held.
    stream_on = 1'b1;
    send(8'hA1, 1'b1, 1'b0);
    send(8'hB2, 1'b1, 1'b0);
    send(8'hC3, 1'b1, 1'b0);
    drop_valid();
    wait_drain();
    stream_on = 1'b0;

    // Random backpressure with idle gaps.
    for (int i = 0; i < 30; i++) begin
      while ($urandom_range(0, 2) == 0) begin
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'($urandom);
      end
      send(8'($urandom), 1'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) drop_valid();
    end
    drop_valid();
    wait_drain();
    chk("rise_count", rises, accepted);

    // Reset during WR_LOW: bus returns to reset values at once and the byte is dropped.
    send(8'h5A, 1'b1, 1'b0);
    drop_valid();
    n = 0;
    while (wrx && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("reached_wr_low", wrx, 0);
    rises_before = rises;
    reset = 1'b0;
    #1;
    chk("abort_wrx_immediate", wrx, 1);
    chk("abort_csx_immediate", csx, 1);
    check_reset_vals();
    chk("abort_pending", expq.size(), 1);
    expq.delete();
    accepted--;
    repeat (2) @(negedge clock);
    release_check();
    repeat (PER + 2) @(negedge clock);
    chk("no_aborted_latch", rises, rises_before);

    send(CMD_DISPON, 1'b0, 1'b0);
    drop_valid();
    wait_drain();
    chk("final_rise_count", rises, accepted);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
